// File: rtl/apb_node_pkg.sv
// Shared types for the APB node: FSM state encoding, decode result and error data default.
package apb_node_pkg;

  // Wide enough for the largest supported port count (32).
  localparam int unsigned IDX_W = 5;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hBADACCE5;

  typedef enum logic [1:0] {
    IDLE,
    MSETUP,
    MACCESS,
    RESP
  } apb_node_state_e;

  typedef struct packed {
    logic             hit;
    logic [IDX_W-1:0] idx;
  } apb_dec_t;

endpackage

// File: rtl/apb_node_tmo_if.sv
// Upstream APB slave port plus the shared/fanned-out downstream APB master signals.
interface apb_node_tmo_if #(
  parameter int unsigned NB_MASTER      = 8,
  parameter int unsigned APB_ADDR_WIDTH = 32,
  parameter int unsigned APB_DATA_WIDTH = 32
);
  // upstream side
  logic                                slv_psel_i;
  logic                                slv_penable_i;
  logic                                slv_pwrite_i;
  logic [APB_ADDR_WIDTH-1:0]           slv_paddr_i;
  logic [APB_DATA_WIDTH-1:0]           slv_pwdata_i;
  logic [APB_DATA_WIDTH-1:0]           slv_prdata_o;
  logic                                slv_pready_o;
  logic                                slv_pslverr_o;
  // downstream side
  logic [NB_MASTER-1:0]                mst_psel_o;
  logic                                mst_penable_o;
  logic                                mst_pwrite_o;
  logic [APB_ADDR_WIDTH-1:0]           mst_paddr_o;
  logic [APB_DATA_WIDTH-1:0]           mst_pwdata_o;
  logic [NB_MASTER*APB_DATA_WIDTH-1:0] mst_prdata_i;
  logic [NB_MASTER-1:0]                mst_pready_i;
  logic [NB_MASTER-1:0]                mst_pslverr_i;

  // The node itself: an APB slave upstream, an APB master downstream.
  modport slave (
    input  slv_psel_i, slv_penable_i, slv_pwrite_i, slv_paddr_i, slv_pwdata_i,
    output slv_prdata_o, slv_pready_o, slv_pslverr_o,
    output mst_psel_o, mst_penable_o, mst_pwrite_o, mst_paddr_o, mst_pwdata_o,
    input  mst_prdata_i, mst_pready_i, mst_pslverr_i
  );

  // The environment: upstream bridge plus the downstream peripherals.
  modport master (
    output slv_psel_i, slv_penable_i, slv_pwrite_i, slv_paddr_i, slv_pwdata_i,
    input  slv_prdata_o, slv_pready_o, slv_pslverr_o,
    input  mst_psel_o, mst_penable_o, mst_pwrite_o, mst_paddr_o, mst_pwdata_o,
    output mst_prdata_i, mst_pready_i, mst_pslverr_i
  );
endinterface

// File: rtl/apb_addr_decoder.sv
// Priority address decoder: lowest-index port whose inclusive window contains the address.
module apb_addr_decoder
  import apb_node_pkg::*;
#(
  parameter int unsigned NB_MASTER      = 8,
  parameter int unsigned APB_ADDR_WIDTH = 32
) (
  input  logic [APB_ADDR_WIDTH-1:0]           addr_i,
  input  logic [NB_MASTER*APB_ADDR_WIDTH-1:0] start_addr_i,
  input  logic [NB_MASTER*APB_ADDR_WIDTH-1:0] end_addr_i,
  output apb_dec_t                            dec_o
);

  logic [NB_MASTER-1:0] match;

  // A reversed window (start > end) can never satisfy both compares, so it never matches.
  generate
    for (genvar gi = 0; gi < NB_MASTER; gi++) begin : g_match
      assign match[gi] = (start_addr_i[gi*APB_ADDR_WIDTH +: APB_ADDR_WIDTH] <= addr_i) &&
                         (addr_i <= end_addr_i[gi*APB_ADDR_WIDTH +: APB_ADDR_WIDTH]);
    end
  endgenerate

  // Scan from the top so the lowest matching index is the one left standing.
  always_comb begin
    dec_o.hit = 1'b0;
    dec_o.idx = '0;
    for (int k = NB_MASTER - 1; k >= 0; k--) begin
      if (match[k]) begin
        dec_o.hit = 1'b1;
        dec_o.idx = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/apb_node_tmo.sv
// Registered APB 1-to-N demux with decode-miss and PREADY-timeout error responses.
module apb_node_tmo
  import apb_node_pkg::*;
#(
  parameter int unsigned NB_MASTER      = 8,
  parameter int unsigned APB_ADDR_WIDTH = 32,
  parameter int unsigned APB_DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter logic [31:0] ERR_DATA       = ERR_DATA_DEFAULT
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  apb_node_tmo_if.slave                       bus,
  input  logic [NB_MASTER*APB_ADDR_WIDTH-1:0] start_addr_i,
  input  logic [NB_MASTER*APB_ADDR_WIDTH-1:0] end_addr_i,
  output logic                                err_pulse_o
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [APB_DATA_WIDTH-1:0] ERR_RDATA = APB_DATA_WIDTH'(ERR_DATA);

  apb_node_state_e           state_q;
  logic [NB_MASTER-1:0]      psel_q;
  logic                      penable_q;
  logic                      pwrite_q;
  logic [APB_ADDR_WIDTH-1:0] paddr_q;
  logic [APB_DATA_WIDTH-1:0] pwdata_q;
  logic [APB_DATA_WIDTH-1:0] prdata_q;
  logic                      pready_q;
  logic                      pslverr_q;
  logic                      err_pulse_q;
  logic                      abort_q;
  logic [CNT_W-1:0]          cnt_q;
  logic [CNT_W-1:0]          cnt_d;

  apb_dec_t                  dec;
  logic [NB_MASTER-1:0]      dec_onehot;
  logic [APB_DATA_WIDTH-1:0] rdata_masked [NB_MASTER];
  logic [APB_DATA_WIDTH-1:0] rdata_sel;
  logic                      tgt_ready;
  logic                      tgt_slverr;
  logic                      timeout_hit;
  logic                      aborted;

  apb_addr_decoder #(
    .NB_MASTER      (NB_MASTER),
    .APB_ADDR_WIDTH (APB_ADDR_WIDTH)
  ) u_dec (
    .addr_i       (bus.slv_paddr_i),
    .start_addr_i (start_addr_i),
    .end_addr_i   (end_addr_i),
    .dec_o        (dec)
  );

  // Per-port one-hot select and read-data gating; psel_q is the registered target during a transfer.
  generate
    for (genvar gi = 0; gi < NB_MASTER; gi++) begin : g_port
      assign dec_onehot[gi]   = dec.hit && (dec.idx == IDX_W'(gi));
      assign rdata_masked[gi] = psel_q[gi] ? bus.mst_prdata_i[gi*APB_DATA_WIDTH +: APB_DATA_WIDTH] : '0;
    end
  endgenerate

  // OR-reduce the gated read data; at most one port is selected.
  always_comb begin
    rdata_sel = '0;
    for (int k = 0; k < NB_MASTER; k++) begin
      rdata_sel = rdata_sel | rdata_masked[k];
    end
  end

  assign tgt_ready   = |(bus.mst_pready_i & psel_q);
  assign tgt_slverr  = |(bus.mst_pslverr_i & psel_q);
  assign cnt_d       = cnt_q + CNT_W'(1);
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  // Upstream dropped PSEL at some point during the downstream transfer.
  assign aborted     = abort_q || !bus.slv_psel_i;

  // Transfer FSM with all bus outputs registered; PREADY and the error pulse default low.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      psel_q      <= '0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      prdata_q    <= '0;
      pready_q    <= 1'b0;
      pslverr_q   <= 1'b0;
      err_pulse_q <= 1'b0;
      abort_q     <= 1'b0;
      cnt_q       <= '0;
    end else begin
      pready_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.slv_psel_i && !bus.slv_penable_i) begin
            paddr_q  <= bus.slv_paddr_i;
            pwdata_q <= bus.slv_pwdata_i;
            pwrite_q <= bus.slv_pwrite_i;
            abort_q  <= 1'b0;
            if (dec.hit) begin
              psel_q  <= dec_onehot;
              cnt_q   <= '0;
              state_q <= MSETUP;
            end else begin
              pready_q    <= 1'b1;
              pslverr_q   <= 1'b1;
              prdata_q    <= bus.slv_pwrite_i ? '0 : ERR_RDATA;
              err_pulse_q <= 1'b1;
              state_q     <= RESP;
            end
          end
        end
        MSETUP: begin
          penable_q <= 1'b1;
          abort_q   <= aborted;
          state_q   <= MACCESS;
        end
        MACCESS: begin
          cnt_q <= cnt_d;
          if (tgt_ready || timeout_hit) begin
            psel_q      <= '0;
            penable_q   <= 1'b0;
            err_pulse_q <= !tgt_ready;
            if (aborted) begin
              state_q <= IDLE;
            end else begin
              pready_q <= 1'b1;
              if (tgt_ready) begin
                pslverr_q <= tgt_slverr;
                prdata_q  <= pwrite_q ? '0 : rdata_sel;
              end else begin
                pslverr_q <= 1'b1;
                prdata_q  <= pwrite_q ? '0 : ERR_RDATA;
              end
              state_q <= RESP;
            end
          end else begin
            abort_q <= aborted;
          end
        end
        RESP: begin
          prdata_q  <= '0;
          pslverr_q <= 1'b0;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.slv_prdata_o  = prdata_q;
  assign bus.slv_pready_o  = pready_q;
  assign bus.slv_pslverr_o = pslverr_q;
  assign bus.mst_psel_o    = psel_q;
  assign bus.mst_penable_o = penable_q;
  assign bus.mst_pwrite_o  = pwrite_q;
  assign bus.mst_paddr_o   = paddr_q;
  assign bus.mst_pwdata_o  = pwdata_q;
  assign err_pulse_o       = err_pulse_q;

endmodule

// File: tb/tb_apb_node_tmo.sv
// Bench for apb_node_tmo: directed scenarios plus randomized transfers against a window/latency model.
module tb_apb_node_tmo;

  localparam int NB  = 8;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 16;
  localparam logic [31:0] ERRD = 32'hBADACCE5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic err_pulse;
  logic [NB*AW-1:0] start_flat, end_flat;

  always #5 clk = ~clk;

  apb_node_tmo_if #(.NB_MASTER(NB), .APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW)) bus ();

  apb_node_tmo #(
    .NB_MASTER(NB), .APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW),
    .TIMEOUT_CYCLES(TMO), .ERR_DATA(ERRD)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus),
    .start_addr_i(start_flat), .end_addr_i(end_flat), .err_pulse_o(err_pulse)
  );

  // windows and downstream slave behaviour
  logic [31:0] win_s [NB];
  logic [31:0] win_e [NB];
  int          p_wait [NB];
  logic [31:0] p_data [NB];
  logic        p_err  [NB];
  int          run = 0;

  int checks = 0;
  int errors = 0;

  always_comb begin
    start_flat = '0;
    end_flat   = '0;
    bus.mst_prdata_i  = '0;
    bus.mst_pready_i  = '0;
    bus.mst_pslverr_i = '0;
    for (int k = 0; k < NB; k++) begin
      start_flat[k*AW +: AW] = win_s[k];
      end_flat[k*AW +: AW]   = win_e[k];
      bus.mst_prdata_i[k*DW +: DW] = p_data[k];
      bus.mst_pslverr_i[k] = p_err[k];
      bus.mst_pready_i[k]  = bus.mst_psel_o[k] & bus.mst_penable_o & (run >= p_wait[k]);
    end
  end

  // number of completed downstream access cycles in the current transfer
  always @(posedge clk) begin
    if (|bus.mst_psel_o && bus.mst_penable_o) run <= run + 1;
    else run <= 0;
  end

  // monitor: running totals, sampled mid-cycle
  logic [31:0] cur_addr = '0, cur_wdata = '0;
  logic        cur_write = 1'b0;
  int acc_total = 0, err_total = 0, bad_total = 0, rdy_total = 0;
  int sel_cnt [NB] = '{default: 0};

  always @(negedge clk) begin
    if (err_pulse) err_total++;
    if (bus.slv_pready_o) rdy_total++;
    for (int k = 0; k < NB; k++) if (bus.mst_psel_o[k]) sel_cnt[k]++;
    if (|bus.mst_psel_o) begin
      if (bus.mst_paddr_o !== cur_addr || bus.mst_pwdata_o !== cur_wdata || bus.mst_pwrite_o !== cur_write)
        bad_total++;
      if (bus.mst_penable_o) acc_total++;
    end
  end

  int acc_base, err_base, bad_base, rdy_base;
  int sel_base [NB];

  task automatic snap();
    acc_base = acc_total; err_base = err_total; bad_base = bad_total; rdy_base = rdy_total;
    for (int k = 0; k < NB; k++) sel_base[k] = sel_cnt[k];
  endtask

  function automatic logic [NB-1:0] sel_mask();
    logic [NB-1:0] m = '0;
    for (int k = 0; k < NB; k++) if (sel_cnt[k] != sel_base[k]) m[k] = 1'b1;
    return m;
  endfunction

  // reference decode: lowest port whose inclusive window holds the address, -1 on a miss
  function automatic int model_port(input logic [31:0] a);
    for (int k = 0; k < NB; k++) if (win_s[k] <= a && a <= win_e[k]) return k;
    return -1;
  endfunction

  task automatic clear_cfg();
    for (int k = 0; k < NB; k++) begin
      win_s[k] = 32'hFFFF_FFFF; win_e[k] = 32'h0;
      p_wait[k] = 0; p_data[k] = 32'h1111_0000 + k; p_err[k] = 1'b0;
    end
  endtask

  // results of the last upstream transfer
  int          x_cyc;
  logic [31:0] x_rd, x_rd_after;
  logic        x_se, x_rdy_after;

  task automatic do_xfer(input logic wr, input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk);
    snap();
    cur_addr = a; cur_wdata = wd; cur_write = wr;
    bus.slv_psel_i = 1'b1; bus.slv_penable_i = 1'b0;
    bus.slv_pwrite_i = wr; bus.slv_paddr_i = a; bus.slv_pwdata_i = wd;
    @(negedge clk);
    bus.slv_penable_i = 1'b1;
    x_cyc = 1;
    while (bus.slv_pready_o !== 1'b1 && x_cyc < 100) begin
      @(negedge clk);
      x_cyc++;
    end
    if (bus.slv_pready_o !== 1'b1) x_cyc = -1;
    x_rd = bus.slv_prdata_o;
    x_se = bus.slv_pslverr_o;
    bus.slv_psel_i = 1'b0; bus.slv_penable_i = 1'b0;
    @(negedge clk);
    x_rdy_after = bus.slv_pready_o;
    x_rd_after  = bus.slv_prdata_o;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (bus.mst_psel_o !== '0 || bus.mst_penable_o !== 1'b0) begin errors++; $display("FAIL reset_psel got %h/%b want 0/0", bus.mst_psel_o, bus.mst_penable_o); end
    checks++; if (bus.slv_pready_o !== 1'b0 || bus.slv_pslverr_o !== 1'b0 || err_pulse !== 1'b0) begin errors++; $display("FAIL reset_resp got %b%b%b want 000", bus.slv_pready_o, bus.slv_pslverr_o, err_pulse); end
    checks++; if ({bus.slv_prdata_o, bus.mst_paddr_o, bus.mst_pwdata_o, bus.mst_pwrite_o} !== '0) begin errors++; $display("FAIL reset_data got %h/%h/%h want 0", bus.slv_prdata_o, bus.mst_paddr_o, bus.mst_pwdata_o); end
    $display("reset: outputs sampled");
  endtask

  task automatic test_write_hit();
    logic [31:0] wd = $urandom;
    clear_cfg();
    win_s[2] = 32'h1000_0000; win_e[2] = 32'h1000_0FFF;
    do_xfer(1'b1, 32'h1000_0004, wd);
    $display("write 10000004 data %h: cyc %0d err %b", wd, x_cyc, x_se);
    checks++; if (sel_mask() !== 8'h04) begin errors++; $display("FAIL wr_psel got %h want 04", sel_mask()); end
    checks++; if (bad_total - bad_base !== 0) begin errors++; $display("FAIL wr_fwd got %0d bad cycles want 0", bad_total - bad_base); end
    checks++; if (x_cyc !== 3) begin errors++; $display("FAIL wr_latency got %0d want 3", x_cyc); end
    checks++; if (x_se !== 1'b0 || x_rd !== 32'h0) begin errors++; $display("FAIL wr_resp got %b/%h want 0/0", x_se, x_rd); end
    checks++; if (x_rdy_after !== 1'b0) begin errors++; $display("FAIL wr_pready_width got %b want 0", x_rdy_after); end
  endtask

  task automatic test_read_wait();
    clear_cfg();
    win_s[5] = 32'h4000_0000; win_e[5] = 32'h4000_00FF;
    p_wait[5] = 4; p_data[5] = 32'hCAFE_F00D;
    do_xfer(1'b0, 32'h4000_0010, 32'h0);
    $display("read 40000010: cyc %0d data %h err %b", x_cyc, x_rd, x_se);
    checks++; if (x_rd !== 32'hCAFE_F00D) begin errors++; $display("FAIL rd_data got %h want cafef00d", x_rd); end
    // setup(1) + MSETUP(1) + 5 cycles from MACCESS entry
    checks++; if (x_cyc !== 7) begin errors++; $display("FAIL rd_latency got %0d want 7", x_cyc); end
    checks++; if (sel_mask() !== 8'h20) begin errors++; $display("FAIL rd_psel got %h want 20", sel_mask()); end
    checks++; if (x_rd_after !== 32'h0) begin errors++; $display("FAIL rd_clear got %h want 0", x_rd_after); end
  endtask

  task automatic test_miss();
    clear_cfg();
    win_s[0] = 32'h0; win_e[0] = 32'h0FFF;
    do_xfer(1'b0, 32'hFFFF_0000, 32'h0);
    $display("read miss ffff0000: cyc %0d data %h err %b", x_cyc, x_rd, x_se);
    checks++; if (sel_mask() !== 8'h00) begin errors++; $display("FAIL miss_psel got %h want 00", sel_mask()); end
    checks++; if (x_se !== 1'b1 || x_rd !== ERRD) begin errors++; $display("FAIL miss_resp got %b/%h want 1/badacce5", x_se, x_rd); end
    checks++; if (err_total - err_base !== 1) begin errors++; $display("FAIL miss_pulse got %0d cycles want 1", err_total - err_base); end
    do_xfer(1'b1, 32'hFFFF_0000, 32'h1234_5678);
    $display("write miss ffff0000: cyc %0d data %h err %b", x_cyc, x_rd, x_se);
    checks++; if (x_se !== 1'b1 || x_rd !== 32'h0) begin errors++; $display("FAIL miss_wr_resp got %b/%h want 1/0", x_se, x_rd); end
  endtask

  task automatic test_timeout();
    clear_cfg();
    win_s[6] = 32'h6000_0000; win_e[6] = 32'h6000_FFFF;
    p_wait[6] = 1000;
    do_xfer(1'b0, 32'h6000_0100, 32'h0);
    $display("read timeout 60000100: cyc %0d data %h err %b", x_cyc, x_rd, x_se);
    checks++; if (acc_total - acc_base !== TMO) begin errors++; $display("FAIL tmo_access got %0d want %0d", acc_total - acc_base, TMO); end
    checks++; if (x_cyc !== TMO + 2) begin errors++; $display("FAIL tmo_latency got %0d want %0d", x_cyc, TMO + 2); end
    checks++; if (x_se !== 1'b1 || x_rd !== ERRD) begin errors++; $display("FAIL tmo_resp got %b/%h want 1/badacce5", x_se, x_rd); end
    checks++; if (err_total - err_base !== 1) begin errors++; $display("FAIL tmo_pulse got %0d want 1", err_total - err_base); end
  endtask

  task automatic test_overlap();
    clear_cfg();
    win_s[0] = 32'h3000; win_e[0] = 32'h1000;   // reversed: must never select
    win_s[1] = 32'h1000; win_e[1] = 32'h2FFF;
    win_s[3] = 32'h2000; win_e[3] = 32'h3FFF;
    do_xfer(1'b0, 32'h2000, 32'h0);
    $display("read overlap 2000: psel mask %h", sel_mask());
    checks++; if (sel_mask() !== 8'h02) begin errors++; $display("FAIL ovl_psel got %h want 02", sel_mask()); end
    do_xfer(1'b0, 32'h3800, 32'h0);
    $display("read 3800: psel mask %h", sel_mask());
    checks++; if (sel_mask() !== 8'h08) begin errors++; $display("FAIL ovl_hi got %h want 08", sel_mask()); end
    do_xfer(1'b0, 32'h0800, 32'h0);
    $display("read 0800: psel mask %h err %b", sel_mask(), x_se);
    checks++; if (sel_mask() !== 8'h00 || x_se !== 1'b1) begin errors++; $display("FAIL reversed_win got %h/%b want 00/1", sel_mask(), x_se); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      logic        wr;
      logic [31:0] a, wd, e_rd;
      int          port, e_cyc, e_err, e_acc;
      logic        e_se;
      logic [NB-1:0] e_mask;
      if (n % 10 == 0) begin
        for (int k = 0; k < NB; k++) begin
          win_s[k] = $urandom_range(0, 32'h7FF);
          win_e[k] = win_s[k] + $urandom_range(0, 32'h300);
          if ($urandom_range(0, 7) == 0) win_e[k] = win_s[k] - 1;
        end
      end
      for (int k = 0; k < NB; k++) begin
        p_wait[k] = $urandom_range(0, 20); p_data[k] = $urandom; p_err[k] = $urandom_range(0, 1);
      end
      wr = $urandom_range(0, 1); a = $urandom_range(0, 32'hBFF); wd = $urandom;
      port = model_port(a);
      if (port < 0) begin
        e_mask = '0; e_cyc = 1; e_se = 1'b1; e_rd = wr ? 32'h0 : ERRD; e_err = 1; e_acc = 0;
      end else if (p_wait[port] < TMO) begin
        e_mask = NB'(1) << port; e_cyc = 3 + p_wait[port]; e_se = p_err[port];
        e_rd = wr ? 32'h0 : p_data[port]; e_err = 0; e_acc = p_wait[port] + 1;
      end else begin
        e_mask = NB'(1) << port; e_cyc = 2 + TMO; e_se = 1'b1;
        e_rd = wr ? 32'h0 : ERRD; e_err = 1; e_acc = TMO;
      end
      do_xfer(wr, a, wd);
      $display("rand %0d: %s addr %h port %0d cyc %0d rd %h err %b", n, wr ? "wr" : "rd", a, port, x_cyc, x_rd, x_se);
      checks++; if (sel_mask() !== e_mask) begin errors++; $display("FAIL rand_psel n=%0d got %h want %h", n, sel_mask(), e_mask); end
      checks++; if (x_cyc !== e_cyc) begin errors++; $display("FAIL rand_latency n=%0d got %0d want %0d", n, x_cyc, e_cyc); end
      checks++; if (x_rd !== e_rd || x_se !== e_se) begin errors++; $display("FAIL rand_resp n=%0d got %h/%b want %h/%b", n, x_rd, x_se, e_rd, e_se); end
      checks++; if (err_total - err_base !== e_err) begin errors++; $display("FAIL rand_pulse n=%0d got %0d want %0d", n, err_total - err_base, e_err); end
      checks++; if (acc_total - acc_base !== e_acc) begin errors++; $display("FAIL rand_access n=%0d got %0d want %0d", n, acc_total - acc_base, e_acc); end
      checks++; if (bad_total - bad_base !== 0 || x_rdy_after !== 1'b0) begin errors++; $display("FAIL rand_hold n=%0d got %0d/%b want 0/0", n, bad_total - bad_base, x_rdy_after); end
    end
  endtask

  task automatic test_protocol_violation();
    clear_cfg();
    win_s[2] = 32'h5000; win_e[2] = 32'h5FFF; p_wait[2] = 3;
    @(negedge clk);
    snap();
    cur_addr = 32'h5010; cur_wdata = 32'hA5A5_0001; cur_write = 1'b1;
    bus.slv_psel_i = 1'b1; bus.slv_penable_i = 1'b0; bus.slv_pwrite_i = 1'b1;
    bus.slv_paddr_i = cur_addr; bus.slv_pwdata_i = cur_wdata;
    @(negedge clk); bus.slv_penable_i = 1'b1;
    @(negedge clk); bus.slv_psel_i = 1'b0; bus.slv_penable_i = 1'b0;
    repeat (12) @(negedge clk);
    $display("violation: access cycles %0d pready cycles %0d", acc_total - acc_base, rdy_total - rdy_base);
    checks++; if (acc_total - acc_base !== 4) begin errors++; $display("FAIL viol_access got %0d want 4", acc_total - acc_base); end
    checks++; if (rdy_total - rdy_base !== 0) begin errors++; $display("FAIL viol_pready got %0d want 0", rdy_total - rdy_base); end
    p_wait[2] = 0;
    do_xfer(1'b0, 32'h5020, 32'h0);
    $display("after violation: cyc %0d rd %h", x_cyc, x_rd);
    checks++; if (x_cyc !== 3 || x_rd !== p_data[2]) begin errors++; $display("FAIL viol_next got %0d/%h want 3/%h", x_cyc, x_rd, p_data[2]); end
  endtask

  task automatic test_reset_mid();
    clear_cfg();
    win_s[2] = 32'h1000_0000; win_e[2] = 32'h1000_0FFF; p_wait[2] = 1000;
    @(negedge clk);
    cur_addr = 32'h1000_0040; cur_wdata = 32'h0; cur_write = 1'b0;
    bus.slv_psel_i = 1'b1; bus.slv_penable_i = 1'b0; bus.slv_pwrite_i = 1'b0;
    bus.slv_paddr_i = cur_addr; bus.slv_pwdata_i = 32'h0;
    @(negedge clk); bus.slv_penable_i = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (bus.mst_penable_o !== 1'b1 || bus.mst_psel_o !== 8'h04) begin errors++; $display("FAIL rstmid_pre got %h/%b want 04/1", bus.mst_psel_o, bus.mst_penable_o); end
    #2 rst_n = 1'b0;
    #1;
    $display("reset mid-access: psel %h penable %b", bus.mst_psel_o, bus.mst_penable_o);
    checks++; if (bus.mst_psel_o !== '0 || bus.mst_penable_o !== 1'b0) begin errors++; $display("FAIL rstmid_psel got %h/%b want 00/0", bus.mst_psel_o, bus.mst_penable_o); end
    checks++; if (bus.slv_pready_o !== 1'b0 || err_pulse !== 1'b0 || bus.slv_prdata_o !== '0) begin errors++; $display("FAIL rstmid_resp got %b/%b/%h want 0/0/0", bus.slv_pready_o, err_pulse, bus.slv_prdata_o); end
    @(negedge clk);
    bus.slv_psel_i = 1'b0; bus.slv_penable_i = 1'b0;
    rst_n = 1'b1;
    p_wait[2] = 0; p_data[2] = 32'h0BAD_F00D;
    do_xfer(1'b0, 32'h1000_0080, 32'h0);
    $display("after reset: cyc %0d rd %h err %b", x_cyc, x_rd, x_se);
    checks++; if (x_cyc !== 3 || x_rd !== 32'h0BAD_F00D || x_se !== 1'b0) begin errors++; $display("FAIL rstmid_next got %0d/%h/%b want 3/0badf00d/0", x_cyc, x_rd, x_se); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.slv_psel_i = 1'b0; bus.slv_penable_i = 1'b0; bus.slv_pwrite_i = 1'b0;
    bus.slv_paddr_i = '0; bus.slv_pwdata_i = '0;
    clear_cfg();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    test_write_hit();
    test_read_wait();
    test_miss();
    test_timeout();
    test_overlap();
    test_random();
    test_protocol_violation();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
